// File: rtl/pipe_issue_if.sv
// pipe_issue_if: instruction handshake plus issued operand bundle for pipe_issue.
// master = instruction source / pipeline observer, slave = the issue stage.
interface pipe_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_instr;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [3:0]  rd;
  logic [3:0]  func;
  logic [7:0]  addr;
  logic        issue_valid;
  logic [15:0] bubble_cnt;
  logic [15:0] issue_cnt;

  modport master (
    output in_valid, in_instr,
    input  in_ready, rs1, rs2, rd, func, addr, issue_valid, bubble_cnt, issue_cnt
  );

  modport slave (
    input  in_valid, in_instr,
    output in_ready, rs1, rs2, rd, func, addr, issue_valid, bubble_cnt, issue_cnt
  );
endinterface

// File: rtl/pipe_issue.sv
// pipe_issue: buffers packed instructions in a small FIFO and issues one operand
// set per clock to the downstream pipeline, substituting a harmless bubble when
// the FIFO is empty or the head would read a register still in flight.
// Optional feature macro: PIPE_ISSUE_HAZARD_EN (scoreboard + RAW stall).
module pipe_issue #(
  parameter int          DEPTH       = 4,
  parameter logic [3:0]  BUBBLE_RD   = 4'd15,
  parameter logic [7:0]  BUBBLE_ADDR = 8'hFF,
  parameter logic [3:0]  BUBBLE_FUNC = 4'd3
`ifdef PIPE_ISSUE_HAZARD_EN
  ,
  parameter int          HAZ_WIN     = 2
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_issue_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] addr;
  } instr_t;

  localparam instr_t BUBBLE = '{func: BUBBLE_FUNC, rd: BUBBLE_RD, rs1: BUBBLE_RD,
                                rs2: BUBBLE_RD, addr: BUBBLE_ADDR};

  instr_t        mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  instr_t        head;
  logic          full, empty, push, pop, hazard;

  instr_t        out_q, out_d;
  logic          valid_q, valid_d;
  logic [15:0]   bubble_cnt_q, bubble_cnt_d;
  logic [15:0]   issue_cnt_q, issue_cnt_d;

  // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && !hazard;

`ifdef PIPE_ISSUE_HAZARD_EN
  logic [HAZ_WIN-1:0] sb_v_q;
  logic [3:0]         sb_rd_q [HAZ_WIN];

  // Head stalls if either source matches any in-flight destination.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (sb_v_q[i] && ((sb_rd_q[i] == head.rs1) || (sb_rd_q[i] == head.rs2)))
        hazard = 1'b1;
    end
  end

  // Scoreboard shifts every edge; bubbles and scratch-rd writers enter invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_v_q <= '0;
      for (int i = 0; i < HAZ_WIN; i++) sb_rd_q[i] <= '0;
    end else begin
      sb_v_q[0]  <= pop && (head.rd != BUBBLE_RD);
      sb_rd_q[0] <= head.rd;
      for (int i = 1; i < HAZ_WIN; i++) begin
        sb_v_q[i]  <= sb_v_q[i-1];
        sb_rd_q[i] <= sb_rd_q[i-1];
      end
    end
  end
`else
  // Without the scoreboard the program guarantees dependency spacing.
  assign hazard = 1'b0;
`endif

  // Next-state for pointers, issued word and counters.
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    out_d        = pop  ? head : BUBBLE;
    valid_d      = pop;
    issue_cnt_d  = issue_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (pop) begin
      if (issue_cnt_q != 16'hFFFF) issue_cnt_d = issue_cnt_q + 16'd1;
    end else begin
      if (bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  // FIFO storage write.
  // NOTE: storage has no reset; an entry is only read after it was written, so
  // clearing it would cost a reset net on every bit for no functional gain.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.in_instr;
  end

  // Control and output registers; reset loads the bubble word.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_q        <= BUBBLE;
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
      issue_cnt_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_q        <= out_d;
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
      issue_cnt_q  <= issue_cnt_d;
    end
  end

  assign bus.in_ready    = !full;
  assign bus.rs1         = out_q.rs1;
  assign bus.rs2         = out_q.rs2;
  assign bus.rd          = out_q.rd;
  assign bus.func        = out_q.func;
  assign bus.addr        = out_q.addr;
  assign bus.issue_valid = valid_q;
  assign bus.bubble_cnt  = bubble_cnt_q;
  assign bus.issue_cnt   = issue_cnt_q;

endmodule

// File: tb/tb_pipe_issue.sv
// tb_pipe_issue: directed and randomized checks of pipe_issue against a
// queue-based model of the issue rules.
module tb_pipe_issue;
  localparam int DEPTH   = 4;
  localparam int HAZ_WIN = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_issue_if bus();

  pipe_issue dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Model state: pending instructions, recent issue history, expected outputs.
  logic [23:0] mq [$];
  bit          hist_v  [HAZ_WIN];
  logic [3:0]  hist_rd [HAZ_WIN];
  logic [3:0]  e_rs1, e_rs2, e_rd, e_func;
  logic [7:0]  e_addr;
  bit          e_valid, e_ready;
  logic [15:0] e_bcnt, e_icnt;

  function automatic logic [23:0] mk(input int f, input int d, input int s1,
                                     input int s2, input int a);
    mk = {f[3:0], d[3:0], s1[3:0], s2[3:0], a[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < HAZ_WIN; i++) begin hist_v[i] = 0; hist_rd[i] = 0; end
    e_rs1 = 15; e_rs2 = 15; e_rd = 15; e_func = 3; e_addr = 8'hFF;
    e_valid = 0; e_ready = 1; e_bcnt = 0; e_icnt = 0;
  endtask

  // One rising edge of the issue rules.
  task automatic model_edge(input bit v, input logic [23:0] w);
    bit          can_push, go;
    logic [23:0] h;
    can_push = (mq.size() < DEPTH);
    go = 0;
    h  = '0;
    if (mq.size() > 0) begin
      h  = mq[0];
      go = 1;
`ifdef PIPE_ISSUE_HAZARD_EN
      for (int i = 0; i < HAZ_WIN; i++)
        if (hist_v[i] && (hist_rd[i] == h[15:12] || hist_rd[i] == h[11:8])) go = 0;
`endif
    end
    for (int i = HAZ_WIN - 1; i > 0; i--) begin
      hist_v[i] = hist_v[i-1]; hist_rd[i] = hist_rd[i-1];
    end
    hist_v[0]  = go && (h[19:16] != 4'd15);
    hist_rd[0] = h[19:16];
    if (go) begin
      void'(mq.pop_front());
      e_func = h[23:20]; e_rd = h[19:16]; e_rs1 = h[15:12]; e_rs2 = h[11:8];
      e_addr = h[7:0]; e_valid = 1;
      if (e_icnt != 16'hFFFF) e_icnt++;
    end else begin
      e_func = 3; e_rd = 15; e_rs1 = 15; e_rs2 = 15; e_addr = 8'hFF; e_valid = 0;
      if (e_bcnt != 16'hFFFF) e_bcnt++;
    end
    if (v && can_push) mq.push_back(w);
    e_ready = (mq.size() < DEPTH);
  endtask

  task automatic compare_all();
    check("rs1",         32'(bus.rs1),         32'(e_rs1));
    check("rs2",         32'(bus.rs2),         32'(e_rs2));
    check("rd",          32'(bus.rd),          32'(e_rd));
    check("func",        32'(bus.func),        32'(e_func));
    check("addr",        32'(bus.addr),        32'(e_addr));
    check("issue_valid", 32'(bus.issue_valid), 32'(e_valid));
    check("in_ready",    32'(bus.in_ready),    32'(e_ready));
    check("bubble_cnt",  32'(bus.bubble_cnt),  32'(e_bcnt));
    check("issue_cnt",   32'(bus.issue_cnt),   32'(e_icnt));
  endtask

  // Called at a negedge: drive, take one edge in DUT and model, compare.
  task automatic cycle(input bit v, input logic [23:0] w);
    bus.in_valid = v;
    bus.in_instr = w;
    @(posedge clk);
    model_edge(v, w);
    @(negedge clk);
    bus.in_valid = 0;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    compare_all();
  endtask

  function automatic int pick_reg();
    pick_reg = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 5));
  endfunction

  initial begin
    logic [15:0] b0;
    rst_n = 0;
    bus.in_valid = 0;
    bus.in_instr = '0;
    model_reset();

    // Reset mid-stream, then released.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    cycle(1, mk(1, 2, 3, 4, 5));
    cycle(1, mk(1, 6, 7, 7, 6));
    do_reset();
    check("rst_rd",    32'(bus.rd), 15);
    check("rst_addr",  32'(bus.addr), 255);
    check("rst_func",  32'(bus.func), 3);
    check("rst_valid", 32'(bus.issue_valid), 0);
    check("rst_ready", 32'(bus.in_ready), 1);
    check("rst_cnt",   32'(bus.issue_cnt) + 32'(bus.bubble_cnt), 0);

    // Independent stream: three consecutive issues in order.
    cycle(1, mk(2, 10, 6, 1, 125));
    check("ind_e1_bubble", 32'(bus.issue_valid), 0);
    cycle(1, mk(3, 12, 9, 8, 126));
    check("ind_e2_rd", 32'(bus.rd), 10);
    check("ind_e2_v",  32'(bus.issue_valid), 1);
    cycle(1, mk(4, 13, 2, 4, 125));
    check("ind_e3_rd", 32'(bus.rd), 12);
    cycle(0, '0);
    check("ind_e4_rd",  32'(bus.rd), 13);
    check("ind_e4_v",   32'(bus.issue_valid), 1);
    check("ind_icnt",   32'(bus.issue_cnt), 3);
    repeat (2) cycle(0, '0);

    // RAW producer/consumer.
    do_reset();
    cycle(1, mk(2, 10, 6, 1, 16));
    cycle(1, mk(3, 11, 10, 0, 17));
    check("raw_p_rd", 32'(bus.rd), 10);
    b0 = bus.bubble_cnt;
    check("raw_b0", 32'(b0), 1);
    cycle(0, '0);
`ifdef PIPE_ISSUE_HAZARD_EN
    check("raw_stall1", 32'(bus.issue_valid), 0);
    cycle(0, '0);
    check("raw_stall2", 32'(bus.issue_valid), 0);
    cycle(0, '0);
    check("raw_c_v",  32'(bus.issue_valid), 1);
    check("raw_c_rd", 32'(bus.rd), 11);
    check("raw_bcnt", 32'(bus.bubble_cnt), 32'(b0) + 2);
`else
    check("nohaz_c_v",  32'(bus.issue_valid), 1);
    check("nohaz_c_rd", 32'(bus.rd), 11);
    check("nohaz_bcnt", 32'(bus.bubble_cnt), 32'(b0));
`endif
    repeat (2) cycle(0, '0);

    // rd=15 producer never stalls its reader.
    do_reset();
    cycle(1, mk(2, 15, 1, 2, 0));
    cycle(1, mk(3, 5, 15, 15, 1));
    check("r15_p_rd", 32'(bus.rd), 15);
    check("r15_p_v",  32'(bus.issue_valid), 1);
    cycle(0, '0);
    check("r15_c_rd", 32'(bus.rd), 5);
    check("r15_c_v",  32'(bus.issue_valid), 1);

`ifdef PIPE_ISSUE_HAZARD_EN
    // Full FIFO: a dependency chain stalls the head while pushes continue.
    do_reset();
    cycle(1, mk(1, 10, 0, 0, 0));
    cycle(1, mk(1, 1, 10, 0, 1));
    cycle(1, mk(1, 2, 1, 0, 2));
    cycle(1, mk(1, 3, 2, 0, 3));
    cycle(1, mk(1, 4, 3, 0, 4));
    cycle(1, mk(1, 5, 4, 0, 5));
    check("full_ready0", 32'(bus.in_ready), 0);
    cycle(1, mk(1, 6, 5, 0, 6));
    check("full_refused", 32'(bus.in_ready), 0);
    cycle(0, '0);
    check("full_ready1", 32'(bus.in_ready), 1);
    check("full_pop_rd", 32'(bus.rd), 2);
    repeat (12) cycle(0, '0);
    check("full_drain_icnt", 32'(bus.issue_cnt), 6);
`endif

    // Randomized traffic with an asynchronous reset partway through.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        #2 rst_n = 0;
        model_reset();
        #1 compare_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        compare_all();
      end
      cycle($urandom_range(0, 3) != 0,
            mk($urandom_range(0, 15), pick_reg(), pick_reg(), pick_reg(),
               $urandom_range(0, 255)));
    end
    repeat (10) cycle(0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
